// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared definitions for the SDRAM device model and the controller's command
//   tasks: command encodings, violation codes, LMR field positions, the read
//   pipe slot layout and a command decoder.
package sdram_pkg;

    localparam int DQ_W       = 16;
    localparam int ROW_W      = 13;
    localparam int BA_W       = 2;
    localparam int NUM_BANKS  = 4;
    localparam int PIPE_DEPTH = 3;   // deepest supported CAS latency

    // Address-bus field positions
    localparam int A10_BIT    = 10;
    localparam int LMR_CL_LSB = 4;
    localparam int LMR_CL_MSB = 6;
    localparam int LMR_BL_LSB = 0;
    localparam int LMR_BL_MSB = 2;

    // {cs, ras, cas, we}, all active-low
    typedef enum logic [3:0] {
        CMD_LMR       = 4'b0000,
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_NOP       = 4'b0111
    } cmd_e;

    // Protocol violation codes; a lower value wins when several apply
    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_ACT_OPEN     = 3'd1,
        ERR_BANK_IDLE    = 3'd2,
        ERR_TRCD         = 3'd3,
        ERR_NO_MODE      = 3'd4,
        ERR_WR_DURING_RD = 3'd5,
        ERR_REF_OPEN     = 3'd6,
        ERR_LMR          = 3'd7
    } err_code_e;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_OPEN = 1'b1
    } bank_state_e;

    // One read-pipe slot: dqm bits are the byte masks captured with the READ
    typedef struct packed {
        logic            valid;
        logic [1:0]      dqm;
        logic [DQ_W-1:0] data;
    } rd_slot_t;

    // Anything with cs high, or an encoding not listed above, is a NOP
    function automatic cmd_e decode_cmd(input logic cs, input logic ras,
                                        input logic cas, input logic we);
        cmd_e c;
        c = CMD_NOP;
        if (!cs) begin
            case ({ras, cas, we})
                3'b011:  c = CMD_ACTIVE;
                3'b101:  c = CMD_READ;
                3'b100:  c = CMD_WRITE;
                3'b010:  c = CMD_PRECHARGE;
                3'b001:  c = CMD_REFRESH;
                3'b000:  c = CMD_LMR;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/sdram_model_rdpipe.sv
// sdram_model_rdpipe
//   CAS-latency shift pipe for read data. A READ accepted at edge T enters
//   slot 0 at T and reaches slot CL-1 at edge T+CL-1, so the output stage holds
//   it from just after T+CL-1 through edge T+CL.
// Ports
//   clock, reset  : clock, synchronous active-low reset (flushes the pipe)
//   flush         : drop everything in flight (write collided with a read)
//   push          : one-cycle strobe, no backpressure; the slot is always taken
//   push_dqm      : byte masks sampled with the READ ([1] = high byte)
//   push_data     : word read from the array at the READ edge
//   cl            : programmed CAS latency (2 or 3)
//   oe            : per-byte output enable for the DQ drivers
//   data          : word at the output stage
//   pending       : a read is in flight and not yet past its data slot
module sdram_model_rdpipe
    import sdram_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic [1:0]      push_dqm,
    input  logic [DQ_W-1:0] push_data,
    input  logic [1:0]      cl,
    output logic [1:0]      oe,
    output logic [DQ_W-1:0] data,
    output logic            pending
);

    rd_slot_t pipe_q [PIPE_DEPTH];
    rd_slot_t head;

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= push ? {1'b1, push_dqm, push_data} : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Output stage is slot CL-1; slots past it hold dead data
    always_comb begin
        head    = (cl == 2'd3) ? pipe_q[2] : pipe_q[1];
        pending = (cl == 2'd3) ? (pipe_q[2].valid | pipe_q[1].valid | pipe_q[0].valid)
                               : (pipe_q[1].valid | pipe_q[0].valid);
        oe      = head.valid ? ~head.dqm : 2'b00;
        data    = head.data;
    end

endmodule

// File: rtl/sdram_model.sv
// sdram_model
//   Device-side model of a single-data-rate SDRAM. Decodes the command bus,
//   keeps a per-bank IDLE/OPEN table with tRCD counters, applies the
//   programmed CAS latency through sdram_model_rdpipe, and stores data in a
//   small on-chip array. Protocol violations latch the first error code.
// Ports
//   clock, reset        : clock, synchronous active-low reset
//   dramCs/Ras/Cas/We   : active-low command strobes
//   dramDQM             : byte masks ([1] = DQ[15:8])
//   dramBA, dramA       : bank and row/column/mode address (A10 = precharge flag)
//   dramDQ              : bidirectional data, driven only in read data slots
//   initDone            : valid mode loaded and >= 2 REFRESH since PRECHARGE-all
//   err, errCode        : sticky first-violation flag and code
module sdram_model
    import sdram_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int COL_BITS = 9,
    parameter int TRCD     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dramCs,
    input  logic              dramRas,
    input  logic              dramCas,
    input  logic              dramWe,
    input  logic [1:0]        dramDQM,
    input  logic [BA_W-1:0]   dramBA,
    input  logic [ROW_W-1:0]  dramA,
    inout  wire  [DQ_W-1:0]   dramDQ,
    output logic              initDone,
    output logic              err,
    output logic [2:0]        errCode
);

    localparam int TRCD_W = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam logic [TRCD_W-1:0] TRCD_LOAD = TRCD_W'(TRCD - 1);
    localparam int MEM_WORDS = 1 << MEM_AW;

    // Bank table and global mode state
    bank_state_e       bank_q [NUM_BANKS];
    bank_state_e       bank_d [NUM_BANKS];
    logic [ROW_W-1:0]  row_q  [NUM_BANKS];
    logic [ROW_W-1:0]  row_d  [NUM_BANKS];
    logic [TRCD_W-1:0] trcd_q [NUM_BANKS];
    logic [TRCD_W-1:0] trcd_d [NUM_BANKS];
    logic [1:0]        ref_q, ref_d;
    logic              mode_valid_q, mode_valid_d;
    logic [1:0]        cl_q, cl_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    // Per-command decode
    cmd_e              cmd;
    logic              any_open;
    logic              ba_open;
    logic [7:1]        hits;
    err_code_e         first_hit;
    logic [2:0]        cl_field;
    logic [2:0]        bl_field;
    logic [1:0]        mem_we;
    logic              rd_push;
    logic              rd_flush;

    // Data path
    logic [DQ_W-1:0]   mem [MEM_WORDS];
    logic [MEM_AW-1:0] mem_addr;
    logic [1:0]        rd_oe;
    logic [DQ_W-1:0]   rd_data;
    logic              rd_pending;

    assign cmd      = decode_cmd(dramCs, dramRas, dramCas, dramWe);
    assign ba_open  = (bank_q[dramBA] == BANK_OPEN);
    assign cl_field = dramA[LMR_CL_MSB:LMR_CL_LSB];
    assign bl_field = dramA[LMR_BL_MSB:LMR_BL_LSB];

    always_comb begin
        any_open = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            any_open = any_open | (bank_q[b] == BANK_OPEN);
        end
    end

    // Stored address is {ba, row, col} LSB-first; upper bits alias
    assign mem_addr = MEM_AW'({dramBA, row_q[dramBA], dramA[COL_BITS-1:0]});

    // Next-state for the bank table, mode, refresh counter and error latch
    always_comb begin
        bank_d       = bank_q;
        row_d        = row_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TRCD_W'(1) : '0;
        end
        ref_d        = ref_q;
        mode_valid_d = mode_valid_q;
        cl_d         = cl_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        hits         = '0;
        mem_we       = 2'b00;
        rd_push      = 1'b0;
        rd_flush     = 1'b0;
        first_hit    = ERR_NONE;

        case (cmd)
            CMD_ACTIVE: begin
                if (ba_open) hits[ERR_ACT_OPEN] = 1'b1;
                bank_d[dramBA] = BANK_OPEN;
                row_d[dramBA]  = dramA;
                trcd_d[dramBA] = TRCD_LOAD;
            end
            CMD_READ, CMD_WRITE: begin
                if (!ba_open) hits[ERR_BANK_IDLE] = 1'b1;
                if (ba_open && trcd_q[dramBA] != '0) hits[ERR_TRCD] = 1'b1;
                if (!mode_valid_q) hits[ERR_NO_MODE] = 1'b1;
                // A write on top of in-flight read data: release the bus
                if (cmd == CMD_WRITE && rd_pending) begin
                    hits[ERR_WR_DURING_RD] = 1'b1;
                    rd_flush = 1'b1;
                end
                // tRCD violations still perform the access; idle bank or no mode drop it
                if (ba_open && mode_valid_q) begin
                    if (cmd == CMD_WRITE) begin
                        mem_we = ~dramDQM;
                    end else begin
                        rd_push = 1'b1;
                    end
                    if (dramA[A10_BIT]) bank_d[dramBA] = BANK_IDLE;
                end
            end
            CMD_PRECHARGE: begin
                if (dramA[A10_BIT]) begin
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        bank_d[b] = BANK_IDLE;
                    end
                    ref_d = 2'd0;
                end else begin
                    bank_d[dramBA] = BANK_IDLE;
                end
            end
            CMD_REFRESH: begin
                if (any_open) begin
                    hits[ERR_REF_OPEN] = 1'b1;
                end else if (ref_q != 2'd3) begin
                    ref_d = ref_q + 2'd1;
                end
            end
            CMD_LMR: begin
                if (any_open) hits[ERR_LMR] = 1'b1;
                // Mode is decoded even when banks are open
                if ((cl_field == 3'd2 || cl_field == 3'd3) && bl_field == 3'd0) begin
                    mode_valid_d = 1'b1;
                    cl_d         = cl_field[1:0];
                end else begin
                    hits[ERR_LMR] = 1'b1;
                    mode_valid_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase

        // Scan downward so the lowest code present is the one kept
        for (int i = 7; i >= 1; i--) begin
            if (hits[i]) first_hit = err_code_e'(i);
        end
        if (!err_q && first_hit != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = first_hit;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= BANK_IDLE;
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
            ref_q        <= 2'd0;
            mode_valid_q <= 1'b0;
            cl_q         <= 2'd2;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            bank_q       <= bank_d;
            row_q        <= row_d;
            trcd_q       <= trcd_d;
            ref_q        <= ref_d;
            mode_valid_q <= mode_valid_d;
            cl_q         <= cl_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    // Storage survives reset, so it has no reset branch
    always_ff @(posedge clock) begin
        if (mem_we[0]) mem[mem_addr][7:0]  <= dramDQ[7:0];
        if (mem_we[1]) mem[mem_addr][15:8] <= dramDQ[15:8];
    end

    sdram_model_rdpipe u_rdpipe (
        .clock     (clock),
        .reset     (reset),
        .flush     (rd_flush),
        .push      (rd_push),
        .push_dqm  (dramDQM),
        .push_data (mem[mem_addr]),
        .cl        (cl_q),
        .oe        (rd_oe),
        .data      (rd_data),
        .pending   (rd_pending)
    );

    assign dramDQ[15:8] = rd_oe[1] ? rd_data[15:8] : 8'bz;
    assign dramDQ[7:0]  = rd_oe[0] ? rd_data[7:0]  : 8'bz;

    assign initDone = mode_valid_q && (ref_q >= 2'd2);
    assign err      = err_q;
    assign errCode  = err_code_q;

endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model
//   Drives command sequences into sdram_model. The DQ bus has pull-ups, so a
//   released bus reads 16'hFFFF; a monitor compares every cycle against the
//   expected-read queue (data due) or the idle value (nothing due).
module tb_sdram_model;

    // {cs, ras, cas, we}
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [1:0]  dqm = 2'b00;
    logic [1:0]  ba = 2'd0;
    logic [12:0] addr = 13'd0;
    logic        tb_drive = 1'b0;
    logic [15:0] tb_dq = 16'h0000;
    tri1  [15:0] dq_bus;
    logic        init_done, err;
    logic [2:0]  err_code;

    always #5 clock = ~clock;

    assign dq_bus = tb_drive ? tb_dq : 16'hzzzz;

    sdram_model dut (
        .clock    (clock),
        .reset    (reset),
        .dramCs   (cs),
        .dramRas  (ras),
        .dramCas  (cas),
        .dramWe   (we),
        .dramDQM  (dqm),
        .dramBA   (ba),
        .dramA    (addr),
        .dramDQ   (dq_bus),
        .initDone (init_done),
        .err      (err),
        .errCode  (err_code)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          due_q[$];
    int          cyc = 0;
    int          cl_model = 2;
    int          test_cnt = 0;
    int          fail_cnt = 0;
    logic        mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        logic [15:0] exp_word;
        #1;
        if (mon_en && !tb_drive) begin
            if (due_q.size() != 0 && due_q[0] < cyc) begin
                test_cnt++;
                fail_cnt++;
                $display("FAIL dq_missed cyc=%0d due=%0d", cyc, due_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end else if (due_q.size() != 0 && due_q[0] == cyc) begin
                exp_word = exp_q.pop_front();
                void'(due_q.pop_front());
                test_cnt++;
                if (dq_bus !== exp_word) begin
                    fail_cnt++;
                    $display("FAIL dq_read cyc=%0d got=%h want=%h", cyc, dq_bus, exp_word);
                end
            end else begin
                test_cnt++;
                if (dq_bus !== BUS_IDLE) begin
                    fail_cnt++;
                    $display("FAIL dq_idle cyc=%0d got=%h want=%h", cyc, dq_bus, BUS_IDLE);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] c, input logic [1:0] b,
                         input logic [12:0] a, input logic [1:0] m);
        {cs, ras, cas, we} = c;
        ba   = b;
        addr = a;
        dqm  = m;
        @(negedge clock);
        {cs, ras, cas, we} = C_NOP;
        dqm = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_write(input logic [1:0] b, input logic [8:0] col,
                            input logic [15:0] d, input logic a10);
        tb_dq    = d;
        tb_drive = 1'b1;
        issue(C_WR, b, {3'b000, a10, 1'b0, col}, 2'b00);
        tb_drive = 1'b0;
    endtask

    // Read with an expectation; masked bytes come back released (pulled high)
    task automatic do_read(input logic [1:0] b, input logic [8:0] col,
                           input logic [1:0] m, input logic [15:0] d);
        logic [15:0] e;
        e = d;
        if (m[1]) e[15:8] = 8'hFF;
        if (m[0]) e[7:0]  = 8'hFF;
        exp_q.push_back(e);
        due_q.push_back(cyc + cl_model);
        issue(C_RD, b, {4'b0000, col}, m);
    endtask

    task automatic drain;
        repeat (cl_model + 3) @(negedge clock);
        #2;
        test_cnt++;
        if (due_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL drain left=%0d want=0", due_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        idle(2);
        exp_q.delete();
        due_q.delete();
        reset = 1'b1;
    endtask

    task automatic check_err(input string name, input logic e, input logic [2:0] code);
        test_cnt++;
        if (err !== e || err_code !== code) begin
            fail_cnt++;
            $display("FAIL %s err=%b code=%0d want err=%b code=%0d", name, err, err_code, e, code);
        end
    endtask

    task automatic init_seq(input logic [12:0] mode, input int cl);
        issue(C_PRE, 2'd0, 13'h0400, 2'b00);
        issue(C_LMR, 2'd0, mode, 2'b00);
        cl_model = cl;
        issue(C_REF, 2'd0, 13'h0000, 2'b00);
        issue(C_REF, 2'd0, 13'h0000, 2'b00);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle(1);
        do_reset();
        mon_en = 1'b1;
        test_cnt++;
        if (init_done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_init_done got=%b want=0", init_done);
        end
        check_err("reset_err", 1'b0, 3'd0);
    endtask

    task automatic test_init;
        issue(C_PRE, 2'd0, 13'h0400, 2'b00);
        issue(C_LMR, 2'd0, 13'h0020, 2'b00);
        cl_model = 2;
        issue(C_REF, 2'd0, 13'h0000, 2'b00);
        test_cnt++;
        if (init_done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL init_one_ref got=%b want=0", init_done);
        end
        issue(C_REF, 2'd0, 13'h0000, 2'b00);
        test_cnt++;
        if (init_done !== 1'b1) begin
            fail_cnt++;
            $display("FAIL init_two_ref got=%b want=1", init_done);
        end
        check_err("init_err", 1'b0, 3'd0);
    endtask

    task automatic test_write_read;
        issue(C_ACT, 2'd1, 13'd5, 2'b00);
        idle(1);
        do_write(2'd1, 9'd3, 16'hA55A, 1'b1);
        issue(C_ACT, 2'd1, 13'd5, 2'b00);
        idle(1);
        do_read(2'd1, 9'd3, 2'b00, 16'hA55A);
        drain();
        do_write(2'd1, 9'd4, 16'h1234, 1'b0);
        do_read(2'd1, 9'd3, 2'b00, 16'hA55A);
        do_read(2'd1, 9'd4, 2'b00, 16'h1234);
        drain();
        check_err("write_read_err", 1'b0, 3'd0);
    endtask

    task automatic test_cl3;
        issue(C_PRE, 2'd0, 13'h0400, 2'b00);
        issue(C_LMR, 2'd0, 13'h0030, 2'b00);
        cl_model = 3;
        test_cnt++;
        if (init_done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL cl3_init_done got=%b want=0", init_done);
        end
        issue(C_ACT, 2'd1, 13'd5, 2'b00);
        idle(1);
        do_read(2'd1, 9'd3, 2'b00, 16'hA55A);
        do_read(2'd1, 9'd3, 2'b10, 16'hA55A);
        drain();
        check_err("cl3_err", 1'b0, 3'd0);
    endtask

    task automatic test_idle_bank;
        issue(C_PRE, 2'd0, 13'h0400, 2'b00);
        issue(C_RD, 2'd2, 13'd0, 2'b00);
        idle(4);
        check_err("read_idle_bank", 1'b1, 3'd2);
        issue(C_ACT, 2'd2, 13'd1, 2'b00);
        issue(C_ACT, 2'd2, 13'd2, 2'b00);
        check_err("sticky_first_code", 1'b1, 3'd2);
    endtask

    task automatic test_trcd;
        do_reset();
        init_seq(13'h0020, 2);
        test_cnt++;
        if (init_done !== 1'b1) begin
            fail_cnt++;
            $display("FAIL trcd_init_done got=%b want=1", init_done);
        end
        issue(C_ACT, 2'd1, 13'd5, 2'b00);
        do_read(2'd1, 9'd3, 2'b00, 16'hA55A);
        drain();
        check_err("trcd_violation", 1'b1, 3'd3);
    endtask

    task automatic test_refresh_and_reset_mid_read;
        do_reset();
        init_seq(13'h0020, 2);
        issue(C_ACT, 2'd0, 13'd0, 2'b00);
        issue(C_REF, 2'd0, 13'd0, 2'b00);
        check_err("refresh_open", 1'b1, 3'd6);
        issue(C_ACT, 2'd1, 13'd5, 2'b00);
        idle(1);
        issue(C_RD, 2'd1, 13'd3, 2'b00);
        reset = 1'b0;
        @(negedge clock);
        check_err("reset_mid_read", 1'b0, 3'd0);
        idle(1);
        reset = 1'b1;
        init_seq(13'h0020, 2);
        issue(C_ACT, 2'd1, 13'd5, 2'b00);
        idle(1);
        do_read(2'd1, 9'd3, 2'b00, 16'hA55A);
        drain();
    endtask

    task automatic test_write_during_read;
        issue(C_RD, 2'd1, 13'd3, 2'b00);
        do_write(2'd1, 9'd5, 16'h0F0F, 1'b0);
        idle(3);
        check_err("write_during_read", 1'b1, 3'd5);
        do_read(2'd1, 9'd5, 2'b00, 16'h0F0F);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_cl3();
        test_idle_bank();
        test_trcd();
        test_refresh_and_reset_mid_read();
        test_write_during_read();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
